rand_gather: RTL and testbench



---
 rtl/rand_gather.sv | 125 ++++++++++++
 tb/tb_rand_gather.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rand_gather.sv
// rtl/rand_gather.sv - packs NUM_SLOTS serial random samples into one wide word
// Optional feature macro: RAND_GATHER_DROP_CNT_EN (adds 16-bit saturating drop_cnt port)
module rand_gather #(
  parameter int NUM_SLOTS    = 5,
  parameter int DATA_IN_SIZE = 7,
  localparam int PTR_W       = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int WORD_W      = NUM_SLOTS * DATA_IN_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_IN_SIZE-1:0] in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WORD_W-1:0]       out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PTR_W-1:0]        slot_idx
`ifdef RAND_GATHER_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_SLOTS - 1);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
  logic [WORD_W-1:0]  fill_buf, fill_nxt;
  logic [WORD_W-1:0]  out_nxt;
  logic               out_valid_nxt;
  logic               accept;
  logic               out_fire;
  logic               last_slot;

  // Sample acceptance: only while collecting, never during flush or reset
  always_comb begin
    in_ready = !rst && (state == FILL) && !flush;
  end

  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_slot = (wr_ptr == LAST_SLOT);
  assign slot_idx  = wr_ptr;

  // Next-state logic: fill buffer writes, word hand-off and HOLD handling
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    fill_nxt      = fill_buf;
    out_nxt       = out;
    out_valid_nxt = out_valid;

    // A consumed word empties the output register unless a new word replaces it below
    if (out_fire) begin
      out_valid_nxt = 1'b0;
    end

    if (flush) begin
      // Partial word and any held complete word are dropped; output side is untouched
      wr_ptr_nxt = '0;
      state_nxt  = FILL;
    end else if (state == HOLD) begin
      if (out_fire) begin
        out_nxt       = fill_buf;
        out_valid_nxt = 1'b1;
        state_nxt     = FILL;
        wr_ptr_nxt    = '0;
      end
    end else if (accept) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (wr_ptr == PTR_W'(k)) begin
          fill_nxt[k*DATA_IN_SIZE +: DATA_IN_SIZE] = in;
        end
      end
      if (last_slot) begin
        wr_ptr_nxt = '0;
        if (!out_valid || out_fire) begin
          // Word including this beat goes straight to the output register
          out_nxt       = fill_nxt;
          out_valid_nxt = 1'b1;
        end else begin
          // Output still occupied: freeze the completed word until it drains
          state_nxt = HOLD;
        end
      end else begin
        wr_ptr_nxt = wr_ptr + 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      wr_ptr    <= '0;
      fill_buf  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      fill_buf  <= fill_nxt;
      out       <= out_nxt;
      out_valid <= out_valid_nxt;
    end
  end

`ifdef RAND_GATHER_DROP_CNT_EN
  // Saturating count of offered samples that were refused
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_valid && !in_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rand_gather.sv
// tb/tb_rand_gather.sv - self-checking bench for rand_gather against a queue-based model
module tb_rand_gather;

  localparam int N  = 5;
  localparam int W  = 7;
  localparam int WW = N * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic [WW-1:0] out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    slot_idx;
`ifdef RAND_GATHER_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: samples collected so far, held-word flag, output register
  logic [W-1:0]  m_fill[$];
  bit            m_hold = 1'b0;
  logic [WW-1:0] m_out = '0;
  bit            m_ov = 1'b0;
  int            m_drop = 0;

  rand_gather #(.NUM_SLOTS(N), .DATA_IN_SIZE(W)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out(out), .out_valid(out_valid), .out_ready(out_ready),
    .slot_idx(slot_idx)
`ifdef RAND_GATHER_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] pack_fill();
    logic [WW-1:0] w = '0;
    foreach (m_fill[k]) w[k*W +: W] = m_fill[k];
    return w;
  endfunction

  // Word whose slot k holds the value first+k
  function automatic logic [WW-1:0] word_seq(input int first);
    logic [WW-1:0] w = '0;
    for (int k = 0; k < N; k++) w[k*W +: W] = W'(first + k);
    return w;
  endfunction

  function automatic bit m_in_ready();
    return !rst && !flush && !m_hold;
  endfunction

  function automatic logic [2:0] m_slot();
    return m_hold ? 3'd0 : 3'(m_fill.size());
  endfunction

  task automatic model_step();
    bit fire, ov0, rdy;
    if (rst) begin
      m_fill.delete(); m_hold = 0; m_out = '0; m_ov = 0; m_drop = 0;
      return;
    end
    rdy = !flush && !m_hold;
    if (in_valid && !rdy && m_drop < 65535) m_drop++;
    ov0  = m_ov;
    fire = m_ov && out_ready;
    if (fire) m_ov = 0;
    if (flush) begin
      m_fill.delete(); m_hold = 0;
    end else if (m_hold) begin
      if (fire) begin
        m_out = pack_fill(); m_ov = 1; m_fill.delete(); m_hold = 0;
      end
    end else if (in_valid) begin
      m_fill.push_back(in);
      if (m_fill.size() == N) begin
        if (!ov0 || fire) begin
          m_out = pack_fill(); m_ov = 1; m_fill.delete();
        end else begin
          m_hold = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; flush = 0; out_ready = 0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
    cycle();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out !== '0) begin errors++; $display("FAIL reset_out got=%h want=0", out); end
    checks++; if (slot_idx !== 3'd0) begin errors++; $display("FAIL reset_slot got=%0d want=0", slot_idx); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < N; i++) begin
      in_valid = 1; in = W'(i + 1);
      #1;
      checks++; if (slot_idx !== 3'(i)) begin errors++; $display("FAIL basic_slot got=%0d want=%0d", slot_idx, i); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
      cycle();
    end
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
    checks++; if (out !== word_seq(1)) begin errors++; $display("FAIL basic_out got=%h want=%h", out, word_seq(1)); end
    checks++; if (slot_idx !== 3'd0) begin errors++; $display("FAIL basic_slot_wrap got=%0d want=0", slot_idx); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b want=0", out_valid); end
    checks++; if (out !== word_seq(1)) begin errors++; $display("FAIL basic_out_kept got=%h want=%h", out, word_seq(1)); end
  endtask

  task automatic test_stall();
    int nxt = 1;
    int stall = 0;
    do_reset();
    out_ready = 0;
    for (int c = 0; c < 40 && stall < 2; c++) begin
      in_valid = 1; in = W'(nxt);
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL stall_in_ready got=%b want=%b", in_ready, m_in_ready()); end
      if (m_in_ready()) nxt++; else stall++;
      cycle();
      checks++; if (out !== m_out || out_valid !== m_ov) begin errors++; $display("FAIL stall_out got=%h/%b want=%h/%b", out, out_valid, m_out, m_ov); end
    end
    checks++; if (stall < 2 || nxt != 11) begin errors++; $display("FAIL stall_timeout got=stall%0d/next%0d want=stall2/next11", stall, nxt); end
    checks++; if (out !== word_seq(1) || out_valid !== 1'b1) begin errors++; $display("FAIL stall_held got=%h want=%h", out, word_seq(1)); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold_ready got=%b want=0", in_ready); end
    out_ready = 1;
    cycle();
    out_ready = 0;
    checks++; if (out !== word_seq(6) || out_valid !== 1'b1) begin errors++; $display("FAIL stall_release got=%h/%b want=%h/1", out, out_valid, word_seq(6)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_resume_ready got=%b want=1", in_ready); end
    cycle();
    in_valid = 0;
    checks++; if (slot_idx !== 3'd1 || slot_idx !== m_slot()) begin errors++; $display("FAIL stall_beat11 got=%0d want=1", slot_idx); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 3 * N; i++) begin
      in_valid = 1; in = W'(i + 1);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
      cycle();
      if ((i % N) == N - 1) begin
        checks++; if (out_valid !== 1'b1 || out !== word_seq(i + 2 - N)) begin errors++; $display("FAIL b2b_word got=%h/%b want=%h/1", out, out_valid, word_seq(i + 2 - N)); end
      end else begin
        checks++; if (out_valid !== m_ov || out !== m_out) begin errors++; $display("FAIL b2b_idle got=%h/%b want=%h/%b", out, out_valid, m_out, m_ov); end
      end
    end
    in_valid = 0;
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1;
    for (int i = 7; i <= 9; i++) begin in_valid = 1; in = W'(i); cycle(); end
    flush = 1; in_valid = 1; in = W'(50);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    cycle();
    flush = 0;
    checks++; if (slot_idx !== 3'd0) begin errors++; $display("FAIL flush_slot got=%0d want=0", slot_idx); end
    for (int i = 20; i <= 24; i++) begin in_valid = 1; in = W'(i); cycle(); end
    in_valid = 0;
    checks++; if (out !== word_seq(20) || out_valid !== 1'b1) begin errors++; $display("FAIL flush_word got=%h/%b want=%h/1", out, out_valid, word_seq(20)); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1;
    for (int i = 1; i <= 2; i++) begin in_valid = 1; in = W'(i); cycle(); end
    in_valid = 0;
    do_reset();
    out_ready = 1;
    checks++; if (out_valid !== 1'b0 || out !== '0 || slot_idx !== 3'd0) begin errors++; $display("FAIL midrst_state got=%h/%b/%0d want=0/0/0", out, out_valid, slot_idx); end
    for (int i = 30; i <= 34; i++) begin in_valid = 1; in = W'(i); cycle(); end
    in_valid = 0;
    checks++; if (out !== word_seq(30) || out_valid !== 1'b1) begin errors++; $display("FAIL midrst_word got=%h/%b want=%h/1", out, out_valid, word_seq(30)); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in        = W'($urandom);
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rand_in_ready c=%0d got=%b want=%b", c, in_ready, m_in_ready()); end
      cycle();
      checks++; if (out_valid !== m_ov || out !== m_out) begin errors++; $display("FAIL rand_out c=%0d got=%h/%b want=%h/%b", c, out, out_valid, m_out, m_ov); end
      checks++; if (slot_idx !== m_slot()) begin errors++; $display("FAIL rand_slot c=%0d got=%0d want=%0d", c, slot_idx, m_slot()); end
`ifdef RAND_GATHER_DROP_CNT_EN
      checks++; if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rand_drop c=%0d got=%0d want=%0d", c, drop_cnt, m_drop); end
`endif
    end
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
  endtask

`ifdef RAND_GATHER_DROP_CNT_EN
  task automatic test_drop_cnt();
    do_reset();
    out_ready = 0;
    for (int i = 1; i <= 10; i++) begin in_valid = 1; in = W'(i); cycle(); end
    for (int s = 0; s < 4; s++) begin in_valid = 1; in = W'(11); cycle(); end
    in_valid = 0;
    checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL drop_count got=%0d want=4", drop_cnt); end
    do_reset();
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL drop_reset got=%0d want=0", drop_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef RAND_GATHER_DROP_CNT_EN
    test_drop_cnt();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
